// File: rtl/bbox_stream_param.sv
// Streaming bounding-box engine: classifies raster-ordered pixel bytes against
// a runtime threshold/polarity and tracks the foreground extremes and the
// foreground pixel count without a frame buffer. Commands and readback share
// the 24-bit index field of hex_value_index.
//
// state  | meaning
// S_IDLE | after reset, waiting for a start command
// S_RUN  | accepting pixel bytes in index order
// S_DONE | frame complete, results held until the next start
module bbox_stream_param #(
  parameter int WIDTH    = 100,
  parameter int HEIGHT   = 100,
  parameter int NUM_CH   = 3,
  parameter int THRESH   = 128,
  parameter int CMD_BASE = 99999
) (
  input  logic        CLOCK_50,
  input  logic        reset_n,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] hex_value_index,
  output logic [31:0] coordinates,
  output logic        done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [63:0] TOTAL    = 64'(WIDTH) * 64'(HEIGHT) * 64'(NUM_CH);
  localparam logic [23:0] C_START  = 24'(CMD_BASE);
  localparam logic [23:0] C_THR    = 24'(CMD_BASE + 1);
  localparam logic [23:0] C_POL    = 24'(CMD_BASE + 2);
  localparam logic [23:0] C_MIN    = 24'(CMD_BASE + 4);
  localparam logic [23:0] C_MAX    = 24'(CMD_BASE + 5);
  localparam logic [23:0] C_CNT    = 24'(CMD_BASE + 6);
  localparam logic [23:0] C_STAT   = 24'(CMD_BASE + 7);
  localparam logic [1:0]  CH_LAST  = 2'(NUM_CH - 1);
  localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);
  localparam logic [7:0]  THR_INIT = 8'(THRESH);

  state_t      state, state_nxt;
  logic [7:0]  data;
  logic [23:0] idx;
  logic [7:0]  thr;
  logic        pol;
  logic        err, empty, last_seen, all_ok;
  logic [15:0] x_min, y_min, x_max, y_max, x_pos, y_pos;
  logic [31:0] fg_count, exp_idx;
  logic [1:0]  ch;
  logic        is_pix, in_order, live, take, bad, is_start, match, fg;
  logic [31:0] rd_data;

  assign data     = hex_value_index[31:24];
  assign idx      = hex_value_index[23:0];
  assign is_start = wr_en && (idx == C_START);
  assign is_pix   = {40'd0, idx} < TOTAL;
  assign in_order = {8'd0, idx} == exp_idx;
  // last_seen closes the window between the final byte and the DONE transition
  assign live     = wr_en && is_pix && (state == S_RUN) && !last_seen;
  assign take     = live && in_order;
  assign bad      = live && !in_order;
  assign match    = pol ? (data > thr) : (data < thr);
  assign fg       = all_ok && match;

  // State register
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: start wins from any state; RUN ends one edge after the last byte
  always_comb begin
    state_nxt = state;
    if (is_start)                            state_nxt = S_RUN;
    else if ((state == S_RUN) && last_seen)  state_nxt = S_DONE;
  end

  // Threshold and polarity configuration, untouched by start
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      thr <= THR_INIT;
      pol <= 1'b0;
    end else if (wr_en) begin
      if (idx == C_THR) thr <= data;
      if (idx == C_POL) pol <= data[0];
    end
  end

  // Pixel datapath: scan position, channel AND, extremes, count and status flags
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      x_min <= 16'hFFFF; y_min <= 16'hFFFF; x_max <= '0; y_max <= '0;
      fg_count <= '0; exp_idx <= '0; ch <= '0; x_pos <= '0; y_pos <= '0;
      all_ok <= 1'b1; err <= 1'b0; empty <= 1'b1; done <= 1'b0; last_seen <= 1'b0;
    end else if (is_start) begin
      x_min <= 16'hFFFF; y_min <= 16'hFFFF; x_max <= '0; y_max <= '0;
      fg_count <= '0; exp_idx <= '0; ch <= '0; x_pos <= '0; y_pos <= '0;
      all_ok <= 1'b1; err <= 1'b0; empty <= 1'b1; done <= 1'b0; last_seen <= 1'b0;
    end else begin
      if (bad) err <= 1'b1;
      if ((state == S_RUN) && last_seen) done <= 1'b1;
      if (take) begin
        exp_idx <= exp_idx + 32'd1;
        if ({32'd0, exp_idx} == TOTAL - 64'd1) last_seen <= 1'b1;
        if (ch == CH_LAST) begin
          ch     <= '0;
          all_ok <= 1'b1;
          if (fg) begin
            if (x_pos < x_min) x_min <= x_pos;
            if (y_pos < y_min) y_min <= y_pos;
            if (x_pos > x_max) x_max <= x_pos;
            if (y_pos > y_max) y_max <= y_pos;
            fg_count <= fg_count + 32'd1;
            empty    <= 1'b0;
          end
          if (x_pos == X_LAST) begin
            x_pos <= '0;
            y_pos <= y_pos + 16'd1;
          end else begin
            x_pos <= x_pos + 16'd1;
          end
        end else begin
          ch     <= ch + 2'd1;
          all_ok <= fg;
        end
      end
    end
  end

  // Readback mux on current (pre-write) register values
  always_comb begin
    rd_data = '0;
    if (idx == C_MIN)       rd_data = {y_min, x_min};
    else if (idx == C_MAX)  rd_data = {y_max, x_max};
    else if (idx == C_CNT)  rd_data = fg_count;
    else if (idx == C_STAT) rd_data = {28'd0, err, empty, done, state == S_RUN};
  end

  // Read data register, held between reads
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n)   coordinates <= '0;
    else if (rd_en) coordinates <= rd_data;
  end

endmodule

// File: tb/tb_bbox_stream_param.sv
// Directed bench for bbox_stream_param on a small 20x12x3 frame with
// procedurally generated images and hand-computed boxes.
module tb_bbox_stream_param;

  localparam int W = 20;
  localparam int H = 12;
  localparam int C = 3;
  localparam int TOTAL = W * H * C;
  localparam int CB = 1000;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] hex_value_index = '0;
  logic [31:0] coordinates;
  logic        done;

  int n_cmp = 0;
  int n_fail = 0;

  bbox_stream_param #(.WIDTH(W), .HEIGHT(H), .NUM_CH(C), .THRESH(128), .CMD_BASE(CB)) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en),
    .hex_value_index(hex_value_index), .coordinates(coordinates), .done(done)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // image 0: triangle, 1: rectangle to last column, 2: all 0xFF,
  // 3: single pixel at bottom-right, 4: triangle with inverted values
  function automatic logic [7:0] pix(input int img, input int i);
    int c, p, x, y;
    logic is_fg;
    logic [7:0] v;
    c = i % C; p = i / C; x = p % W; y = p / W;
    case (img)
      0, 4:    is_fg = (x >= 4) && (y <= 10) && ((x - 4) <= (y - 2));
      1:       is_fg = (x >= 5) && (y >= 3) && (y <= 9);
      3:       is_fg = (x == W - 1) && (y == H - 1);
      default: is_fg = 1'b0;
    endcase
    if (img == 2)   v = 8'hFF;
    else if (is_fg) v = (c == 0) ? 8'd50 : (c == 1) ? 8'd127 : 8'd0;
    else            v = (c == 0) ? ((y == 0) ? 8'd50 : 8'd200) : (c == 1) ? 8'd128 : ((x == 0) ? 8'd5 : 8'd255);
    if (img == 4) v = 8'hFF - v;
    return v;
  endfunction

  task automatic put(input int idx, input logic [7:0] d);
    @(negedge CLOCK_50);
    wr_en = 1'b1;
    hex_value_index = {d, 24'(idx)};
    @(posedge CLOCK_50);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic rd(input int idx, output logic [31:0] v);
    @(negedge CLOCK_50);
    rd_en = 1'b1;
    hex_value_index = {8'd0, 24'(idx)};
    @(posedge CLOCK_50);
    #1;
    rd_en = 1'b0;
    v = coordinates;
  endtask

  task automatic send(input int img, input int from, input int upto);
    for (int i = from; i < upto; i++) put(i, pix(img, i));
  endtask

  task automatic frame_end(input string tag);
    chk({tag, "_done_lag"}, {31'd0, done}, 32'd0);
    @(posedge CLOCK_50);
    #1;
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
  endtask

  task automatic results(input string tag, input logic [31:0] e4, input logic [31:0] e5,
                         input logic [31:0] e6, input logic [31:0] e7);
    logic [31:0] v;
    rd(CB + 4, v); chk({tag, "_min"}, v, e4);
    rd(CB + 5, v); chk({tag, "_max"}, v, e5);
    rd(CB + 6, v); chk({tag, "_cnt"}, v, e6);
    rd(CB + 7, v); chk({tag, "_stat"}, v, e7);
  endtask

  initial begin
    logic [31:0] v;
    #12;
    chk("rst_coord", coordinates, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    results("rst", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h4);

    put(0, 8'd0);
    rd(CB + 7, v); chk("idle_pix_ignored", v, 32'h4);

    put(CB, 8'd0);
    rd(CB + 7, v); chk("run_stat", v, 32'h5);
    send(0, 0, TOTAL);
    frame_end("tri");
    results("tri", 32'h0002_0004, 32'h000A_000C, 32'd45, 32'h2);
    rd(CB + 4, v);
    repeat (3) @(posedge CLOCK_50);
    #1;
    chk("rd_hold", coordinates, 32'h0002_0004);
    rd(CB + 3, v); chk("rd_unmapped", v, 32'd0);

    put(CB, 8'd0);
    send(1, 0, TOTAL);
    frame_end("rect");
    results("rect", 32'h0003_0005, 32'h0009_0013, 32'd105, 32'h2);

    put(CB, 8'd0);
    send(2, 0, TOTAL);
    frame_end("empty");
    results("empty", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h6);

    put(CB, 8'd0);
    send(3, 0, TOTAL);
    frame_end("single");
    results("single", 32'h000B_0013, 32'h000B_0013, 32'd1, 32'h2);

    put(CB, 8'd0);
    send(0, 0, 3);
    put(5, pix(0, 5));
    rd(CB + 7, v); chk("ooo_err", v, 32'hD);
    send(0, 3, TOTAL);
    frame_end("resend");
    results("resend", 32'h0002_0004, 32'h000A_000C, 32'd45, 32'hA);
    put(0, 8'd0);
    rd(CB + 7, v); chk("done_pix_ignored", v, 32'hA);

    put(CB + 1, 8'd10);
    put(CB + 2, 8'd1);
    put(CB, 8'd0);
    send(0, 0, TOTAL / 2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_coord", coordinates, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
    results("midrst", 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h4);
    put(CB, 8'd0);
    send(0, 0, TOTAL);
    frame_end("after_rst");
    results("after_rst", 32'h0002_0004, 32'h000A_000C, 32'd45, 32'h2);

    put(CB + 1, 8'd127);
    put(CB + 2, 8'd1);
    put(CB, 8'd0);
    send(4, 0, TOTAL);
    frame_end("inv");
    results("inv", 32'h0002_0004, 32'h000A_000C, 32'd45, 32'h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
